// File: rtl/lazy_match_scheduler_if.sv
// Job, lazy-match request, summary and sequence signals between the scheduler and its environment.
// The slave modport is the scheduler side; master is whatever drives jobs, summaries and seq_ready.
interface lazy_match_scheduler_if #(
   parameter int JOB_LEN_LOG2    = 5,
   parameter int SEQ_LL_BITS     = 8,
   parameter int SEQ_ML_BITS     = 8,
   parameter int SEQ_OFFSET_BITS = 16
);
   logic                       i_job_valid;
   logic                       i_job_delim;
   logic                       o_job_ready;
   logic                       o_match_req;
   logic [JOB_LEN_LOG2-1:0]    o_match_head_ptr;
   logic [JOB_LEN_LOG2-1:0]    o_seq_head_ptr;
   logic                       o_match_delim;
   logic                       i_summary_done;
   logic [SEQ_LL_BITS-1:0]     i_summary_ll;
   logic [SEQ_ML_BITS-1:0]     i_summary_ml;
   logic [SEQ_OFFSET_BITS-1:0] i_summary_offset;
   logic                       i_summary_eoj;
   logic [SEQ_ML_BITS-1:0]     i_summary_overlap;
   logic [JOB_LEN_LOG2-1:0]    i_move_forward;
   logic                       o_seq_valid;
   logic                       i_seq_ready;
   logic [SEQ_LL_BITS-1:0]     o_seq_ll;
   logic [SEQ_ML_BITS-1:0]     o_seq_ml;
   logic [SEQ_OFFSET_BITS-1:0] o_seq_offset;
   logic                       o_seq_eoj;
   logic                       o_seq_delim;
   logic                       o_busy;

   modport slave (
      input  i_job_valid, i_job_delim, i_summary_done, i_summary_ll, i_summary_ml,
             i_summary_offset, i_summary_eoj, i_summary_overlap, i_move_forward, i_seq_ready,
      output o_job_ready, o_match_req, o_match_head_ptr, o_seq_head_ptr, o_match_delim,
             o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim, o_busy
   );

   modport master (
      output i_job_valid, i_job_delim, i_summary_done, i_summary_ll, i_summary_ml,
             i_summary_offset, i_summary_eoj, i_summary_overlap, i_move_forward, i_seq_ready,
      input  o_job_ready, o_match_req, o_match_head_ptr, o_seq_head_ptr, o_match_delim,
             o_seq_valid, o_seq_ll, o_seq_ml, o_seq_offset, o_seq_eoj, o_seq_delim, o_busy
   );
endinterface

// File: rtl/lazy_match_scheduler.sv
// Per-job sequencer around the lazy summary pipeline: one request in flight, one sequence out,
// match overlap carried into the following job.
module lazy_match_scheduler #(
   parameter int JOB_LEN_LOG2    = 5,
   parameter int LAZY_LEN        = 4,
   parameter int SEQ_LL_BITS     = 8,
   parameter int SEQ_ML_BITS     = 8,
   parameter int SEQ_OFFSET_BITS = 16
) (
   input logic                    clk,
   input logic                    rst,
   lazy_match_scheduler_if.slave  bus
);
   localparam int JOB_LEN = 1 << JOB_LEN_LOG2;
   localparam logic [JOB_LEN_LOG2:0]  JOB_LEN_X  = (JOB_LEN_LOG2+1)'(JOB_LEN);
   localparam logic [JOB_LEN_LOG2:0]  LAZY_X     = (JOB_LEN_LOG2+1)'(LAZY_LEN);
   localparam logic [SEQ_ML_BITS-1:0] JOB_LEN_ML = SEQ_ML_BITS'(JOB_LEN);
   localparam logic [SEQ_LL_BITS-1:0] JOB_LEN_LL = SEQ_LL_BITS'(JOB_LEN);

   typedef logic [JOB_LEN_LOG2-1:0] ptr_t;
   typedef struct packed {
      logic [SEQ_LL_BITS-1:0]     ll;
      logic [SEQ_ML_BITS-1:0]     ml;
      logic [SEQ_OFFSET_BITS-1:0] offset;
      logic                       eoj;
      logic                       delim;
   } seq_t;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, SKIP} state_t;

   state_t                 state;
   ptr_t                   seq_head, match_head;
   logic                   job_delim;
   logic [SEQ_ML_BITS-1:0] carry;
   seq_t                   seq;
   logic                   seq_valid, job_ready, match_req, busy;

   // Window end uses one extra bit so reaching JOB_LEN is visible rather than wrapping to 0.
   logic [JOB_LEN_LOG2:0]  lazy_end;
   ptr_t                   fwd_head;
   assign lazy_end = {1'b0, match_head} + LAZY_X;
   assign fwd_head = seq_head + bus.i_move_forward;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         seq_head   <= '0;
         match_head <= '0;
         job_delim  <= 1'b0;
         carry      <= '0;
         seq        <= '0;
         seq_valid  <= 1'b0;
         job_ready  <= 1'b0;
         match_req  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         match_req <= 1'b0;
         case (state)
            IDLE: begin
               job_ready <= 1'b1;
               if (job_ready && bus.i_job_valid) begin
                  job_ready <= 1'b0;
                  busy      <= 1'b1;
                  job_delim <= bus.i_job_delim;
                  if (32'(carry) >= JOB_LEN) begin
                     state <= SKIP;
                  end else begin
                     seq_head   <= ptr_t'(carry);
                     match_head <= ptr_t'(carry);
                     carry      <= '0;
                     match_req  <= 1'b1;
                     state      <= ISSUE;
                  end
               end
            end
            ISSUE: state <= WAIT;
            WAIT: begin
               if (bus.i_summary_done) begin
                  if (bus.i_summary_eoj) begin
                     seq       <= '{bus.i_summary_ll, bus.i_summary_ml, bus.i_summary_offset, 1'b1, job_delim};
                     carry     <= job_delim ? '0 : bus.i_summary_overlap;
                     seq_valid <= 1'b1;
                     state     <= EMIT;
                  end else if (bus.i_summary_ml != '0) begin
                     seq        <= '{bus.i_summary_ll, bus.i_summary_ml, bus.i_summary_offset, 1'b0, 1'b0};
                     seq_head   <= fwd_head;
                     match_head <= fwd_head;
                     seq_valid  <= 1'b1;
                     state      <= EMIT;
                  end else begin
                     // No match in this window: slide it, or close the job with a literal tail.
                     match_head <= ptr_t'(lazy_end);
                     if (lazy_end >= JOB_LEN_X) begin
                        seq       <= '{JOB_LEN_LL - SEQ_LL_BITS'(seq_head), '0, '0, 1'b1, job_delim};
                        carry     <= '0;
                        seq_valid <= 1'b1;
                        state     <= EMIT;
                     end else begin
                        match_req <= 1'b1;
                        state     <= ISSUE;
                     end
                  end
               end
            end
            EMIT: begin
               if (bus.i_seq_ready) begin
                  seq_valid <= 1'b0;
                  if (seq.eoj) begin
                     job_ready <= 1'b1;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     match_req <= 1'b1;
                     state     <= ISSUE;
                  end
               end
            end
            SKIP: begin
               // Previous match covered this whole job; emit an empty closing sequence.
               seq       <= '{'0, '0, '0, 1'b1, job_delim};
               carry     <= job_delim ? '0 : carry - JOB_LEN_ML;
               seq_valid <= 1'b1;
               state     <= EMIT;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_job_ready      = job_ready;
   assign bus.o_match_req      = match_req;
   assign bus.o_match_head_ptr = match_head;
   assign bus.o_seq_head_ptr   = seq_head;
   assign bus.o_match_delim    = job_delim;
   assign bus.o_seq_valid      = seq_valid;
   assign bus.o_seq_ll         = seq.ll;
   assign bus.o_seq_ml         = seq.ml;
   assign bus.o_seq_offset     = seq.offset;
   assign bus.o_seq_eoj        = seq.eoj;
   assign bus.o_seq_delim      = seq.delim;
   assign bus.o_busy           = busy;
endmodule
